traffic_phase_scheduler: RTL and testbench

- Timed phase scheduler for an N-approach intersection. It grants green to one vehicle approach at a time and serves a latched pedestrian request as an exclusive walk phase.
- Sequencing is GREEN -> YELLOW -> ALL-RED clearance. Vehicle approaches are chosen round-robin.
- It generalizes the two-road light controller into a parameterized controller driven by a 1-cycle timing strobe.

---
 rtl/traffic_pkg.sv | 17 +
 rtl/rr_picker.sv | 26 ++
 rtl/traffic_phase_scheduler.sv | 152 +++++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared light codes and phase encoding for the intersection phase scheduler.
package traffic_pkg;

    typedef enum logic [1:0] {
        RED    = 2'b00,
        YELLOW = 2'b01,
        GREEN  = 2'b10
    } light_t;

    typedef enum logic [1:0] {
        PH_ALLRED = 2'b00,
        PH_GREEN  = 2'b01,
        PH_YELLOW = 2'b10,
        PH_WALK   = 2'b11
    } phase_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin first-set search: the first requester after 'last', wrapping around.
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] pick,
    output logic          any_req
);

    assign any_req = |req;

    // Scan from farthest to nearest so the closest hit after 'last' wins.
    always_comb begin
        int j;
        pick = '0;
        for (int k = N; k >= 1; k--) begin
            j = (int'(last) + k) % N;
            if (req[IW'(j)]) begin
                pick = IW'(j);
            end
        end
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Tick-timed GREEN/YELLOW/ALL-RED scheduler with round-robin approaches and an exclusive walk phase.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int N_APPROACH = 4,
    parameter int GREEN_MIN  = 5,
    parameter int GREEN_MAX  = 20,
    parameter int YELLOW_T   = 3,
    parameter int ALLRED_T   = 1,
    parameter int WALK_T     = 4,
    parameter int CNT_W      = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          tick,
    input  logic [N_APPROACH-1:0]         sensor,
    input  logic                          ped_req,
    output logic [2*N_APPROACH-1:0]       light,
    output logic                          ped_walk,
    output logic [$clog2(N_APPROACH)-1:0] active_idx,
    output logic                          phase_start
);

    localparam int IW = $clog2(N_APPROACH);
    localparam logic [CNT_W-1:0] GMIN_END   = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_END   = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YELLOW_END = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] ALLRED_END = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] WALK_END   = CNT_W'(WALK_T - 1);

    phase_t                    state_reg, state_next;
    logic [CNT_W-1:0]          cnt_reg, cnt_next;
    logic [IW-1:0]             last_reg, last_next;
    logic [IW-1:0]             idx_reg, idx_next;
    logic                      ped_pending_reg, ped_pending_next;
    logic                      from_walk_reg, from_walk_next;
    logic [2*N_APPROACH-1:0]   light_reg, light_next;
    logic                      ped_walk_reg;
    logic                      phase_start_reg;
    logic                      enter;
    logic [IW-1:0]             pick;
    logic                      any_req;
    logic [N_APPROACH-1:0]     active_onehot;
    logic                      other;

    rr_picker #(
        .N  (N_APPROACH),
        .IW (IW)
    ) u_picker (
        .req     (sensor),
        .last    (last_reg),
        .pick    (pick),
        .any_req (any_req)
    );

    assign active_onehot = {{(N_APPROACH-1){1'b0}}, 1'b1} << idx_reg;
    assign other         = (|(sensor & ~active_onehot)) | ped_pending_reg;

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        last_next      = last_reg;
        from_walk_next = from_walk_reg;
        enter          = 1'b0;
        if (tick) begin
            case (state_reg)
                PH_ALLRED: if (cnt_reg >= ALLRED_END) begin
                    // A walk never follows a walk while vehicles are waiting.
                    if (ped_pending_reg && (!from_walk_reg || !any_req)) begin
                        state_next = PH_WALK;
                        enter      = 1'b1;
                    end else if (any_req) begin
                        state_next = PH_GREEN;
                        idx_next   = pick;
                        last_next  = pick;
                        enter      = 1'b1;
                    end
                end
                PH_GREEN: if (other && ((cnt_reg >= GMIN_END && !sensor[idx_reg]) ||
                                        cnt_reg >= GMAX_END)) begin
                    state_next = PH_YELLOW;
                    enter      = 1'b1;
                end
                PH_YELLOW: if (cnt_reg >= YELLOW_END) begin
                    state_next     = PH_ALLRED;
                    from_walk_next = 1'b0;
                    enter          = 1'b1;
                end
                default: if (cnt_reg >= WALK_END) begin
                    state_next     = PH_ALLRED;
                    from_walk_next = 1'b1;
                    enter          = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        cnt_next = cnt_reg;
        if (enter) begin
            cnt_next = '0;
        end else if (tick && cnt_reg != '1) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    assign ped_pending_next = (enter && state_next == PH_WALK) ? 1'b0
                                                               : (ped_pending_reg | ped_req);

    for (genvar gi = 0; gi < N_APPROACH; gi++) begin : g_light
        always_comb begin
            light_next[2*gi +: 2] = RED;
            if (idx_next == IW'(gi)) begin
                if (state_next == PH_GREEN) begin
                    light_next[2*gi +: 2] = GREEN;
                end else if (state_next == PH_YELLOW) begin
                    light_next[2*gi +: 2] = YELLOW;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= PH_ALLRED;
            cnt_reg         <= '0;
            last_reg        <= IW'(N_APPROACH - 1);
            idx_reg         <= '0;
            ped_pending_reg <= 1'b0;
            from_walk_reg   <= 1'b0;
            light_reg       <= '0;
            ped_walk_reg    <= 1'b0;
            phase_start_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            last_reg        <= last_next;
            idx_reg         <= idx_next;
            ped_pending_reg <= ped_pending_next;
            from_walk_reg   <= from_walk_next;
            light_reg       <= light_next;
            ped_walk_reg    <= (state_next == PH_WALK);
            phase_start_reg <= enter;
        end
    end

    assign light       = light_reg;
    assign ped_walk    = ped_walk_reg;
    assign active_idx  = idx_reg;
    assign phase_start = phase_start_reg;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed checks of the phase scheduler with default parameters.
module tb_traffic_phase_scheduler;

    logic       clk;
    logic       reset;
    logic       tick;
    logic [3:0] sensor;
    logic       ped_req;
    logic [7:0] light;
    logic       ped_walk;
    logic [1:0] active_idx;
    logic       phase_start;

    int checks = 0;
    int errors = 0;

    traffic_phase_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .sensor      (sensor),
        .ped_req     (ped_req),
        .light       (light),
        .ped_walk    (ped_walk),
        .active_idx  (active_idx),
        .phase_start (phase_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance n active edges, then settle 1 time unit past the last one.
    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        tick    = 1'b1;
        sensor  = 4'b0100;
        ped_req = 1'b0;
        #1 reset = 1'b0;
        #3;
        chk("rst_light", light, 8'h00);
        chk("rst_walk", ped_walk, 1'b0);
        chk("rst_idx", active_idx, 2'd0);
        chk("rst_pstart", phase_start, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Single requester on approach 2
        adv(1);
        chk("a2_green", light, 8'h20);
        chk("a2_idx", active_idx, 2'd2);
        chk("a2_pstart", phase_start, 1'b1);
        adv(1);
        chk("a2_pstart_lo", phase_start, 1'b0);
        adv(100);
        chk("a2_rest", light, 8'h20);

        // Pedestrian latch then asynchronous reset mid-green
        ped_req = 1'b1;
        sensor  = 4'b0000;
        adv(1);
        ped_req = 1'b0;
        chk("pre_rst_green", light, 8'h20);
        reset = 1'b0;
        #1;
        chk("async_light", light, 8'h00);
        chk("async_walk", ped_walk, 1'b0);
        chk("async_idx", active_idx, 2'd0);
        #3 reset = 1'b1;
        adv(5);
        chk("post_rst_walk", ped_walk, 1'b0);
        chk("post_rst_light", light, 8'h00);

        // Two requesters 0 and 2: max-green alternation with wrap
        sensor = 4'b0101;
        adv(1);
        chk("s0_green", light, 8'h02);
        chk("s0_idx", active_idx, 2'd0);
        chk("s0_pstart", phase_start, 1'b1);
        adv(19);
        chk("s0_green_19", light, 8'h02);
        adv(1);
        chk("s0_yellow", light, 8'h01);
        chk("s0_y_pstart", phase_start, 1'b1);
        adv(2);
        chk("s0_yellow_3", light, 8'h01);
        adv(1);
        chk("s0_allred", light, 8'h00);
        chk("s0_ar_pstart", phase_start, 1'b1);
        adv(1);
        chk("s2_green", light, 8'h20);
        chk("s2_idx", active_idx, 2'd2);
        adv(19);
        chk("s2_green_19", light, 8'h20);
        adv(1);
        chk("s2_yellow", light, 8'h10);
        adv(3);
        chk("s2_allred", light, 8'h00);
        chk("s2_ar_idx", active_idx, 2'd2);
        adv(1);
        chk("wrap_green0", light, 8'h02);
        chk("wrap_idx", active_idx, 2'd0);

        // Early exit at GREEN_MIN after sensor[0] drops
        sensor = 4'b0011;
        adv(2);
        sensor = 4'b0010;
        adv(2);
        chk("min_green_4", light, 8'h02);
        adv(1);
        chk("min_yellow", light, 8'h01);
        adv(3);
        chk("min_allred", light, 8'h00);
        adv(1);
        chk("a1_green", light, 8'h08);
        chk("a1_idx", active_idx, 2'd1);

        // Pedestrian pulse during approach 1 green, approach 3 waiting
        sensor  = 4'b1010;
        ped_req = 1'b1;
        adv(1);
        ped_req = 1'b0;
        sensor  = 4'b1000;
        adv(3);
        chk("p_green_4", light, 8'h08);
        adv(1);
        chk("p_yellow", light, 8'h04);
        adv(3);
        chk("p_allred", light, 8'h00);
        chk("p_ar_walk", ped_walk, 1'b0);
        adv(1);
        chk("p_walk", ped_walk, 1'b1);
        chk("p_walk_light", light, 8'h00);
        chk("p_walk_pstart", phase_start, 1'b1);
        adv(3);
        chk("p_walk_4", ped_walk, 1'b1);
        adv(1);
        chk("p_walk_end", ped_walk, 1'b0);
        chk("p_ar2_pstart", phase_start, 1'b1);
        adv(1);
        chk("a3_green", light, 8'h80);
        chk("a3_idx", active_idx, 2'd3);

        // Freeze tick mid-yellow
        sensor = 4'b1001;
        adv(19);
        chk("a3_green_19", light, 8'h80);
        adv(1);
        chk("a3_yellow", light, 8'h40);
        adv(1);
        tick = 1'b0;
        adv(50);
        chk("frz_light", light, 8'h40);
        chk("frz_pstart", phase_start, 1'b0);
        chk("frz_idx", active_idx, 2'd3);
        tick = 1'b1;
        adv(1);
        chk("frz_yellow_3", light, 8'h40);
        adv(1);
        chk("frz_allred", light, 8'h00);
        adv(1);
        chk("frz_green0", light, 8'h02);
        chk("frz_idx0", active_idx, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
